cache_line_arbiter: RTL and testbench
=====================================

Name: cache_line_arbiter

Overview:
- Memory-side responder for the split L1 caches.
- Accepts cache-line read requests from the I-cache and read/writeback requests from the D-cache.
- Forwards one request at a time to the physical-memory port, then returns one full line and a one-cycle response to the requester.
- Sits between both cache controllers/datapaths and the physical-memory interface; it is the block that drives the I-cache's arbiter rdata/resp inputs.

Parameters:
- WIDTH, 256, cache line width in bits (physical_mem_word).
- W_OFFSET, $clog2(WIDTH/8), byte-offset bits cleared in the memory address.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_read  in  1  I-cache line read request; held until i_resp
- i_addr  in  32  I-cache request address
- i_resp  out  1  one-cycle pulse: i_rdata valid, request complete
- i_rdata  out  WIDTH  line returned to I-cache
- d_read  in  1  D-cache line read request; held until d_resp
- d_write  in  1  D-cache line writeback request; held until d_resp
- d_addr  in  32  D-cache request address
- d_wdata  in  WIDTH  writeback line
- d_resp  out  1  one-cycle pulse: read data valid or write done
- d_rdata  out  WIDTH  line returned to D-cache
- pmem_read  out  1  memory read strobe, held until pmem_resp
- pmem_write  out  1  memory write strobe, held until pmem_resp
- pmem_addr  out  32  line-aligned memory address
- pmem_wdata  out  WIDTH  writeback line to memory
- pmem_resp  in  1  memory completion pulse
- pmem_rdata  in  WIDTH  memory read line, valid with pmem_resp

Behaviour:
- Clocking and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - state IDLE; all resp/pmem strobes 0.
  - pmem_addr, pmem_wdata, i_rdata, d_rdata all 0.
  - last_grant = D, so the I-cache wins the first tie.
- FSM states: IDLE, SERVE_I, SERVE_D_RD, SERVE_D_WR, RESP_I, RESP_D.
- IDLE:
  - No request pending: stay.
  - Exactly one requester pending: grant it.
  - Both pending: grant the one not granted last (round-robin on last_grant).
  - On grant, register pmem_addr = {addr[31:W_OFFSET], W_OFFSET'0}.
  - On a D-cache write grant, also register pmem_wdata = d_wdata.
  - Update last_grant.
- D-cache request type: d_write has precedence if d_read and d_write are both high. That combination is illegal; the bench asserts on it.
- SERVE_*: pmem_read or pmem_write is high, Moore output decoded from state, exactly one at a time.
  - Address and wdata are stable for the whole transaction.
  - Requester inputs are ignored after grant; they are not re-sampled.
- pmem_resp in SERVE_*:
  - Capture pmem_rdata into i_rdata or d_rdata (read only; unchanged for write).
  - Go to RESP_I or RESP_D.
- RESP_*:
  - The matching resp is high for exactly one cycle, with registered data valid the same cycle.
  - Next state is IDLE.
  - No new grant occurs in RESP_*, so the requester has one cycle to drop its request.
- Latency: grant on the request cycle edge, so pmem strobe is visible the next cycle. The requester sees resp one cycle after pmem_resp. Minimum request-to-resp is 3 cycles with 1-cycle memory.
- rdata registers hold their value until the next read completion for that requester.
- pmem_resp outside SERVE_* is ignored.
- Reset mid-transaction: return to IDLE immediately, drop pmem strobes, emit no resp. Memory is assumed to be reset together.
- A requester that drops its request before resp is unsupported. The transaction still completes and resp still pulses.

Test Plan:
- Single I-read: i_read=1, i_addr=0x0000_1234; memory resp after 4 cycles with 0xAA..AA.
  - pmem_addr=0x0000_1220 and pmem_read=1 for 4 cycles.
  - i_resp pulses once with i_rdata=0xAA..AA; pmem_write stays 0.
- D-writeback: d_write=1, d_addr=0x8000_00FF, d_wdata=0x55..55.
  - pmem_write=1, pmem_addr=0x8000_00E0, pmem_wdata=0x55..55.
  - d_resp one pulse; i_resp=0 throughout.
- Contention after reset: i_read and d_read raised in the same cycle.
  - I is served first, then D.
  - Next simultaneous pair: I first again (last_grant=D). If D was last served alone, then I wins.
- Back-to-back round-robin: I and D both request continuously for 4 transactions.
  - Grants alternate I, D, I, D.
  - Exactly one IDLE cycle after each RESP.
- Reset mid-transaction: rst during SERVE_D_RD.
  - Next cycle pmem_read=0, state IDLE, d_resp never asserted.
  - A following i_read is served normally.
- Stray pmem_resp in IDLE: no resp output and no state change.

Source files
------------

// File: rtl/cache_line_arbiter.sv
`default_nettype none
// cache_line_arbiter: round-robin arbiter of I-cache and D-cache line requests onto one memory port.
// Rev 1.0
module cache_line_arbiter #(
  parameter int WIDTH    = 256,
  parameter int W_OFFSET = $clog2(WIDTH/8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_read,
  input  logic [31:0]      i_addr,
  output logic             i_resp,
  output logic [WIDTH-1:0] i_rdata,
  input  logic             d_read,
  input  logic             d_write,
  input  logic [31:0]      d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_resp,
  output logic [WIDTH-1:0] d_rdata,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [31:0]      pmem_addr,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic             pmem_resp,
  input  logic [WIDTH-1:0] pmem_rdata
);

  localparam logic [31:0] ADDR_MASK = ~((32'd1 << W_OFFSET) - 32'd1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SERVE_I    = 3'd1,
    SERVE_D_RD = 3'd2,
    SERVE_D_WR = 3'd3,
    RESP_I     = 3'd4,
    RESP_D     = 3'd5
  } state_t;

  state_t state;
  logic   last_grant_d;
  logic   d_req;
  logic   grant_i;

  // On a tie the requester not served last wins; a lone requester always wins.
  assign d_req   = d_read | d_write;
  assign grant_i = i_read & (~d_req | last_grant_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant_d <= 1'b1;
      i_resp       <= 1'b0;
      d_resp       <= 1'b0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_addr    <= '0;
      pmem_wdata   <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i) begin
            state        <= SERVE_I;
            pmem_read    <= 1'b1;
            pmem_addr    <= i_addr & ADDR_MASK;
            last_grant_d <= 1'b0;
          end else if (d_req) begin
            pmem_addr    <= d_addr & ADDR_MASK;
            last_grant_d <= 1'b1;
            // Writeback wins if both D strobes are (illegally) high.
            if (d_write) begin
              state      <= SERVE_D_WR;
              pmem_write <= 1'b1;
              pmem_wdata <= d_wdata;
            end else begin
              state      <= SERVE_D_RD;
              pmem_read  <= 1'b1;
            end
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            state     <= RESP_I;
            pmem_read <= 1'b0;
            i_rdata   <= pmem_rdata;
            i_resp    <= 1'b1;
          end
        end
        SERVE_D_RD: begin
          if (pmem_resp) begin
            state     <= RESP_D;
            pmem_read <= 1'b0;
            d_rdata   <= pmem_rdata;
            d_resp    <= 1'b1;
          end
        end
        SERVE_D_WR: begin
          if (pmem_resp) begin
            state      <= RESP_D;
            pmem_write <= 1'b0;
            d_resp     <= 1'b1;
          end
        end
        RESP_I, RESP_D: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_line_arbiter.sv
`default_nettype none
// tb_cache_line_arbiter: directed self-checking bench for cache_line_arbiter.
// Rev 1.0
module tb_cache_line_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [31:0]  i_addr;
  logic         i_resp;
  logic [255:0] i_rdata;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic         d_resp;
  logic [255:0] d_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;

  cache_line_arbiter #(.WIDTH(256)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst) assert (!(d_read && d_write)) else $error("illegal d_read+d_write");
  end

  // Memory model: answers after mem_lat strobe cycles; data is mem_data or the address pattern.
  int           mem_lat   = 1;
  bit           mem_pat   = 1'b1;
  logic [255:0] mem_data  = '0;
  int           stray_cyc = -1;
  int           cyc;
  int           mcnt;

  initial begin
    cyc = 0; mcnt = 0; pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (pmem_resp) begin
        pmem_resp = 1'b0; mcnt = 0;
      end else if (pmem_read || pmem_write) begin
        mcnt++;
        if (mcnt >= mem_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_pat ? {8{pmem_addr}} : mem_data;
        end
      end else begin
        mcnt = 0;
      end
      if (cyc == stray_cyc) begin
        pmem_resp = 1'b1; pmem_rdata = '1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observation state updated every cycle by tick().
  int           rd_cyc, wr_cyc, iresp_n, dresp_n, tcyc, last_resp_cyc;
  bit           prev_strobe, auto_drop;
  int           stop_after;
  logic [31:0]  grant_q[$];
  logic [255:0] wdata_at_grant;
  int           gap_q[$];

  task automatic clear_obs();
    rd_cyc = 0; wr_cyc = 0; iresp_n = 0; dresp_n = 0; last_resp_cyc = -1;
    grant_q.delete(); gap_q.delete(); wdata_at_grant = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    tcyc++;
    if (pmem_read)  rd_cyc++;
    if (pmem_write) wr_cyc++;
    if (pmem_read && pmem_write) check("strobe_excl", 256'(1), 256'(0));
    if ((pmem_read || pmem_write) && !prev_strobe) begin
      grant_q.push_back(pmem_addr);
      wdata_at_grant = pmem_wdata;
      if (last_resp_cyc >= 0) gap_q.push_back(tcyc - last_resp_cyc);
    end
    prev_strobe = pmem_read || pmem_write;
    if (i_resp) begin
      iresp_n++; last_resp_cyc = tcyc;
      if (auto_drop) i_read = 1'b0;
    end
    if (d_resp) begin
      dresp_n++; last_resp_cyc = tcyc;
      if (auto_drop) begin d_read = 1'b0; d_write = 1'b0; end
    end
    if (!auto_drop && (iresp_n + dresp_n >= stop_after)) begin
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    end
  endtask

  task automatic wait_resps(input int n, input int bound);
    int k;
    k = 0;
    while ((iresp_n + dresp_n) < n && k < bound) begin
      tick(); k++;
    end
    check("timeout", 256'((iresp_n + dresp_n) >= n), 256'(1));
    tick(); tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    tcyc = 0; prev_strobe = 1'b0; auto_drop = 1'b1; stop_after = 1000;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    clear_obs();
    do_reset();
    check("rst_i_resp",  256'(i_resp), 256'(0));
    check("rst_d_resp",  256'(d_resp), 256'(0));
    check("rst_pread",   256'(pmem_read), 256'(0));
    check("rst_pwrite",  256'(pmem_write), 256'(0));
    check("rst_paddr",   256'(pmem_addr), 256'(0));
    check("rst_pwdata",  pmem_wdata, 256'(0));
    check("rst_i_rdata", i_rdata, 256'(0));
    check("rst_d_rdata", d_rdata, 256'(0));

    // Single I-cache read, 4-cycle memory.
    clear_obs();
    mem_pat = 1'b0; mem_data = {32{8'hAA}}; mem_lat = 4;
    i_addr = 32'h0000_1234; i_read = 1'b1;
    wait_resps(1, 30);
    check("i1_addr",   256'(grant_q.size() > 0 ? grant_q[0] : 32'hDEAD), 256'(32'h0000_1220));
    check("i1_rdcyc",  256'(rd_cyc), 256'(4));
    check("i1_wrcyc",  256'(wr_cyc), 256'(0));
    check("i1_iresp",  256'(iresp_n), 256'(1));
    check("i1_dresp",  256'(dresp_n), 256'(0));
    check("i1_rdata",  i_rdata, {32{8'hAA}});

    // D-cache writeback.
    clear_obs();
    mem_lat = 2;
    d_addr = 32'h8000_00FF; d_wdata = {32{8'h55}}; d_write = 1'b1;
    wait_resps(1, 30);
    check("dw_addr",   256'(grant_q.size() > 0 ? grant_q[0] : 32'hDEAD), 256'(32'h8000_00E0));
    check("dw_wdata",  wdata_at_grant, {32{8'h55}});
    check("dw_wrcyc",  256'(wr_cyc), 256'(2));
    check("dw_rdcyc",  256'(rd_cyc), 256'(0));
    check("dw_dresp",  256'(dresp_n), 256'(1));
    check("dw_iresp",  256'(iresp_n), 256'(0));
    check("dw_drdata", d_rdata, 256'(0));

    // Contention after reset: I, D; then I first again; D alone; then I first.
    do_reset();
    clear_obs();
    mem_pat = 1'b1; mem_lat = 1;
    i_addr = 32'h100; d_addr = 32'h200; i_read = 1'b1; d_read = 1'b1;
    wait_resps(2, 40);
    i_addr = 32'h300; d_addr = 32'h400; i_read = 1'b1; d_read = 1'b1;
    wait_resps(4, 40);
    d_addr = 32'h500; d_read = 1'b1;
    wait_resps(5, 40);
    i_addr = 32'h600; d_addr = 32'h700; i_read = 1'b1; d_read = 1'b1;
    wait_resps(7, 40);
    check("ct_ngrant", 256'(grant_q.size()), 256'(7));
    if (grant_q.size() == 7) begin
      check("ct_g0", 256'(grant_q[0]), 256'(32'h100));
      check("ct_g1", 256'(grant_q[1]), 256'(32'h200));
      check("ct_g2", 256'(grant_q[2]), 256'(32'h300));
      check("ct_g3", 256'(grant_q[3]), 256'(32'h400));
      check("ct_g5", 256'(grant_q[5]), 256'(32'h600));
      check("ct_g6", 256'(grant_q[6]), 256'(32'h700));
    end
    check("ct_irdata", i_rdata, {8{32'h600}});
    check("ct_drdata", d_rdata, {8{32'h700}});

    // Back-to-back round robin with both requesters held high.
    clear_obs();
    auto_drop = 1'b0; stop_after = 4;
    i_addr = 32'h1000; d_addr = 32'h2000; i_read = 1'b1; d_read = 1'b1;
    wait_resps(4, 60);
    auto_drop = 1'b1; stop_after = 1000;
    check("rr_ngrant", 256'(grant_q.size()), 256'(4));
    for (int g = 0; g < 4 && g < grant_q.size(); g++)
      check($sformatf("rr_g%0d", g), 256'(grant_q[g]), 256'((g % 2 == 0) ? 32'h1000 : 32'h2000));
    check("rr_ngap", 256'(gap_q.size()), 256'(3));
    foreach (gap_q[g]) check($sformatf("rr_gap%0d", g), 256'(gap_q[g]), 256'(2));

    // Reset in the middle of a D-cache read.
    clear_obs();
    mem_lat = 20;
    d_addr = 32'h3000; d_read = 1'b1;
    for (int k = 0; k < 10 && !pmem_read; k++) tick();
    check("mr_started", 256'(pmem_read), 256'(1));
    tick();
    rst = 1'b1;
    tick();
    check("mr_pread",  256'(pmem_read), 256'(0));
    check("mr_pwrite", 256'(pmem_write), 256'(0));
    rst = 1'b0; d_read = 1'b0;
    for (int k = 0; k < 25; k++) tick();
    check("mr_dresp",  256'(dresp_n), 256'(0));
    check("mr_idle",   256'(pmem_read), 256'(0));
    clear_obs();
    mem_lat = 1;
    i_addr = 32'h4000; i_read = 1'b1;
    wait_resps(1, 30);
    check("mr_i_addr",  256'(grant_q.size() > 0 ? grant_q[0] : 32'hDEAD), 256'(32'h4000));
    check("mr_i_rdata", i_rdata, {8{32'h4000}});

    // Stray pmem_resp while idle.
    clear_obs();
    stray_cyc = cyc + 3;
    for (int k = 0; k < 8; k++) tick();
    check("st_iresp", 256'(iresp_n), 256'(0));
    check("st_dresp", 256'(dresp_n), 256'(0));
    check("st_rdcyc", 256'(rd_cyc), 256'(0));
    check("st_drdata_hold", d_rdata, 256'(0));
    clear_obs();
    d_addr = 32'h5000; d_read = 1'b1;
    wait_resps(1, 30);
    check("st_d_addr",  256'(grant_q.size() > 0 ? grant_q[0] : 32'hDEAD), 256'(32'h5000));
    check("st_d_rdata", d_rdata, {8{32'h5000}});
    check("st_i_hold",  i_rdata, {8{32'h4000}});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
